lfsr_range_sampler: RTL and testbench



---
 rtl/lfsr_range_sampler_pkg.sv | 18 +
 rtl/lfsr_range_sampler_sync_fifo.sv | 54 +++++
 rtl/lfsr_range_sampler.sv | 91 +++++++++
 tb/tb_lfsr_range_sampler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_range_sampler_pkg.sv
// Shared constants and types for the LFSR range sampler: LFSR geometry,
// FSM state encoding and the output-width helper.
package lfsr_range_sampler_pkg;

  localparam int LFSR_W   = 8;
  localparam int LFSR_MAX = 255;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Width needed to hold 0..range-1, never below one bit.
  function automatic int out_width(input int range);
    return (range <= 2) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/lfsr_range_sampler_sync_fifo.sv
// Small synchronous FIFO holding sampler results; head entry is presented
// directly on pop_data while valid, zero when empty.
module lfsr_range_sampler_sync_fifo #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (level_reg != LW'(DEPTH));
  assign pop_ok  = pop && (level_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so increments wrap on their own.
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  assign valid    = (level_reg != '0);
  assign pop_data = valid ? mem[rd_ptr_reg] : '0;
  assign level    = level_reg;

endmodule

// File: rtl/lfsr_range_sampler.sv
// Rejection-samples an 8-bit LFSR stream into uniform values in [0,RANGE),
// buffers them and throttles the LFSR so the buffer can never overflow.
module lfsr_range_sampler
  import lfsr_range_sampler_pkg::*;
#(
  parameter  int RANGE = 6,
  parameter  int DEPTH = 4,
  localparam int OW    = out_width(RANGE),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_ready,
  input  logic [LFSR_W-1:0] src_value,
  output logic              src_enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data,
  output logic [LW-1:0]     fifo_level,
  output logic              lockup_err
);

  // Largest multiple of RANGE not above LFSR_MAX; u below it maps uniformly.
  localparam logic [LFSR_W-1:0] LIMIT = LFSR_W'((LFSR_MAX / RANGE) * RANGE);

  state_t            state_reg;
  state_t            state_next;
  logic              a_v_reg;
  logic [LFSR_W-1:0] a_u_reg;
  logic              b_v_reg;
  logic [OW-1:0]     b_d_reg;
  logic              lockup_reg;
  logic [LW:0]       in_flight;
  logic [LFSR_W-1:0] u;
  logic              err_cond;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT:  if (src_ready)  state_next = S_RUN;
      S_RUN:   if (!src_ready) state_next = S_WAIT;
      default: state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_WAIT;
    else       state_reg <= state_next;
  end

  // Credits count FIFO entries plus both pipeline slots; a pop in the same
  // cycle is deliberately not credited.
  assign in_flight  = (LW+1)'(fifo_level) + (LW+1)'(a_v_reg) + (LW+1)'(b_v_reg);
  assign src_enable = (state_reg == S_RUN) && src_ready && (in_flight < (LW+1)'(DEPTH));

  assign u        = src_value - 1'b1;
  assign err_cond = src_enable && ((src_value == '0) || $isunknown(src_value));

  always_ff @(posedge clk) begin
    if (reset) begin
      a_v_reg    <= 1'b0;
      a_u_reg    <= '0;
      b_v_reg    <= 1'b0;
      b_d_reg    <= '0;
      lockup_reg <= 1'b0;
    end else begin
      a_v_reg <= src_enable && (u < LIMIT) && !err_cond;
      if (src_enable) a_u_reg <= u;
      b_v_reg <= a_v_reg;
      b_d_reg <= OW'(a_u_reg % LFSR_W'(RANGE));
      if (err_cond) lockup_reg <= 1'b1;
    end
  end

  lfsr_range_sampler_sync_fifo #(
    .WIDTH (OW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (b_v_reg),
    .push_data (b_d_reg),
    .pop       (out_ready),
    .pop_data  (out_data),
    .valid     (out_valid),
    .level     (fifo_level)
  );

  assign lockup_err = lockup_reg;

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Directed bench for lfsr_range_sampler (RANGE=6, DEPTH=4) plus a histogram
// run against a maximal-length 8-bit Galois LFSR.
module tb_lfsr_range_sampler;

  logic       clk;
  logic       reset;
  logic       src_ready;
  logic [7:0] src_value;
  logic       src_enable;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic [2:0] fifo_level;
  logic       lockup_err;

  logic [7:0] dir_value;
  logic [7:0] lfsr = 8'h01;
  logic       lfsr_mode;
  logic [2:0] got_q[$];
  int         hist[6];
  int         hist_bad;
  int         n_lfsr;
  int         checks;
  int         errors;

  lfsr_range_sampler #(.RANGE(6), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_ready  (src_ready),
    .src_value  (src_value),
    .src_enable (src_enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .lockup_err (lockup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign src_value = lfsr_mode ? lfsr : dir_value;

  // Galois LFSR, taps 0xB8 (x^8+x^6+x^5+x^4+1), steps only when consumed.
  always @(posedge clk) begin
    if (lfsr_mode && src_enable)
      lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      if (lfsr_mode) begin
        n_lfsr++;
        if (out_data < 3'd6) hist[out_data]++;
        else hist_bad++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present v and return just after the edge that consumes it.
  task automatic feed(input logic [7:0] v);
    bit done;
    done = 1'b0;
    dir_value = v;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (src_enable) done = 1'b1;
    end
    if (!done) check("feed_timeout", 32'd0, 32'd1);
    tick();
  endtask

  function automatic logic [2:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 3'h7;
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    hist_bad  = 0;
    n_lfsr    = 0;
    lfsr_mode = 1'b0;
    dir_value = 8'h07;
    reset     = 1'b1;
    src_ready = 1'b1;
    out_ready = 1'b0;

    // 1: reset held three cycles with src_ready high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_src_enable", src_enable, 1'b0);
      check("t1_out_valid", out_valid, 1'b0);
      check("t1_out_data", out_data, 3'd0);
      check("t1_fifo_level", fifo_level, 3'd0);
      check("t1_lockup_err", lockup_err, 1'b0);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t1_wait_after_reset", src_enable, 1'b0);

    // 2: latency of a single accepted sample, then the mixed sequence
    feed(8'h07);
    src_ready = 1'b0;
    @(negedge clk);
    check("t2_lat_t1", out_valid, 1'b0);
    @(negedge clk);
    check("t2_lat_t2", out_valid, 1'b0);
    @(negedge clk);
    check("t2_lat_valid", out_valid, 1'b1);
    check("t2_lat_data", out_data, 3'd0);
    tick();
    got_q.delete();
    out_ready = 1'b1;
    src_ready = 1'b1;
    feed(8'hFC);
    feed(8'hFD);
    feed(8'hFF);
    feed(8'h01);
    src_ready = 1'b0;
    repeat (8) tick();
    check("t2_count", got_q.size(), 3);
    check("t2_out0", got_at(0), 3'd0);
    check("t2_out1", got_at(1), 3'd5);
    check("t2_out2", got_at(2), 3'd0);

    // 3: back-pressure fills exactly DEPTH entries
    got_q.delete();
    out_ready = 1'b0;
    src_ready = 1'b1;
    feed(8'h02);
    feed(8'h03);
    feed(8'h04);
    feed(8'h05);
    dir_value = 8'h06;
    repeat (6) tick();
    @(negedge clk);
    check("t3_level_full", fifo_level, 3'd4);
    check("t3_src_enable_low", src_enable, 1'b0);
    check("t3_out_valid", out_valid, 1'b1);
    check("t3_head", out_data, 3'd1);
    @(negedge clk);
    check("t3_head_stable", out_data, 3'd1);
    tick();
    src_ready = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    check("t3_count", got_q.size(), 4);
    check("t3_out0", got_at(0), 3'd1);
    check("t3_out1", got_at(1), 3'd2);
    check("t3_out2", got_at(2), 3'd3);
    check("t3_out3", got_at(3), 3'd4);
    check("t3_level_empty", fifo_level, 3'd0);

    // 4: zero sample raises sticky lockup_err and yields nothing
    got_q.delete();
    src_ready = 1'b1;
    feed(8'h00);
    src_ready = 1'b0;
    @(negedge clk);
    check("t4_lockup_set", lockup_err, 1'b1);
    repeat (5) tick();
    check("t4_no_output", got_q.size(), 0);
    check("t4_lockup_sticky", lockup_err, 1'b1);
    src_ready = 1'b1;
    feed(8'h0E);
    src_ready = 1'b0;
    repeat (6) tick();
    check("t4_after_count", got_q.size(), 1);
    check("t4_after_data", got_at(0), 3'd1);
    check("t4_lockup_still", lockup_err, 1'b1);

    // 5: reset with items in both pipeline stages and the FIFO
    out_ready = 1'b0;
    src_ready = 1'b1;
    feed(8'h08);
    feed(8'h09);
    feed(8'h0A);
    feed(8'h0B);
    src_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t5_pre_level", fifo_level, 3'd2);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_level", fifo_level, 3'd0);
    check("t5_lockup_cleared", lockup_err, 1'b0);
    repeat (4) tick();
    check("t5_pipe_flushed", fifo_level, 3'd0);
    check("t5_idle_enable", src_enable, 1'b0);
    src_ready = 1'b1;
    dir_value = 8'h01;
    @(negedge clk);
    check("t5_resume_wait", src_enable, 1'b0);
    @(negedge clk);
    check("t5_resume_run", src_enable, 1'b1);

    // 6: histogram over 10000 outputs from the real LFSR
    tick();
    lfsr_mode = 1'b1;
    begin
      int cyc;
      for (cyc = 0; cyc < 40000 && n_lfsr < 10000; cyc++) begin
        tick();
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    lfsr_mode = 1'b0;
    src_ready = 1'b0;
    check("t6_enough_outputs", (n_lfsr >= 10000), 1'b1);
    check("t6_out_of_range", hist_bad, 0);
    for (int i = 0; i < 6; i++) begin
      int diff;
      diff = hist[i] * 6 - n_lfsr;
      if (diff < 0) diff = -diff;
      check($sformatf("t6_bin%0d_within_5pct", i), (diff * 20 <= n_lfsr), 1'b1);
    end
    check("t6_no_lockup", lockup_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
